// File: rtl/chess_click_if.sv
`default_nettype none
// =============================================================================
// Module   : chess_click_if
// Brief    : Mouse/cursor/move-request bundle between the click controller
//            and its environment (mouse driver, sprite renderer, game logic).
// Revision : 1.0
// =============================================================================
interface chess_click_if;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       left_btn;
    logic       right_btn;
    logic       frame_start;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic       sel_valid;
    logic [2:0] sel_col;
    logic [2:0] sel_row;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] src_col;
    logic [2:0] src_row;
    logic [2:0] dst_col;
    logic [2:0] dst_row;
    logic       busy;

    modport slave (
        input  mouse_x, mouse_y, left_btn, right_btn, frame_start, move_ready,
        output cursor_x, cursor_y, sel_valid, sel_col, sel_row, move_valid,
               src_col, src_row, dst_col, dst_row, busy
    );

    modport master (
        output mouse_x, mouse_y, left_btn, right_btn, frame_start, move_ready,
        input  cursor_x, cursor_y, sel_valid, sel_col, sel_row, move_valid,
               src_col, src_row, dst_col, dst_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/chess_click_controller.sv
`default_nettype none
// =============================================================================
// Module   : chess_click_controller
// Brief    : Cursor latch, click-to-square conversion and move-request FSM.
// Revision : 1.0
// =============================================================================
module chess_click_controller #(
    parameter int BOARD_X0 = 140,
    parameter int BOARD_Y0 = 60,
    parameter int SQ       = 45,
    parameter int MAX_X    = 623,
    parameter int MAX_Y    = 463
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    chess_click_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CONV_SRC = 3'd1;
    localparam logic [2:0] S_SRC_HELD = 3'd2;
    localparam logic [2:0] S_CONV_DST = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;

    localparam logic [9:0] c_X0    = 10'(BOARD_X0);
    localparam logic [9:0] c_Y0    = 10'(BOARD_Y0);
    localparam logic [9:0] c_X1    = 10'(BOARD_X0 + 8 * SQ - 1);
    localparam logic [9:0] c_Y1    = 10'(BOARD_Y0 + 8 * SQ - 1);
    localparam logic [8:0] c_RX0   = 9'(BOARD_X0);
    localparam logic [8:0] c_RY0   = 9'(BOARD_Y0);
    localparam logic [8:0] c_SQ    = 9'(SQ);
    localparam logic [9:0] c_MAX_X = 10'(MAX_X);
    localparam logic [9:0] c_MAX_Y = 10'(MAX_Y);

    logic [2:0] r_state;
    logic       r_prev_left;
    logic       r_prev_right;
    logic       r_lclick;
    logic       r_rclick;
    logic [9:0] r_click_x;
    logic [9:0] r_click_y;
    logic [8:0] r_rel_x;
    logic [8:0] r_rel_y;
    logic [2:0] r_cnt_x;
    logic [2:0] r_cnt_y;
    logic [2:0] r_step;
    logic [9:0] r_cursor_x;
    logic [9:0] r_cursor_y;
    logic       r_sel_valid;
    logic [2:0] r_sel_col;
    logic [2:0] r_sel_row;
    logic       r_move_valid;
    logic [2:0] r_src_col;
    logic [2:0] r_src_row;
    logic [2:0] r_dst_col;
    logic [2:0] r_dst_row;

    logic       w_lclick;
    logic       w_rclick;
    logic       w_accept;
    logic       w_in_board;
    logic       w_converting;
    logic [8:0] w_rel_x;
    logic [8:0] w_rel_y;
    logic       w_ge_x;
    logic       w_ge_y;
    logic [8:0] w_nrel_x;
    logic [8:0] w_nrel_y;
    logic [2:0] w_ncnt_x;
    logic [2:0] w_ncnt_y;

    assign w_lclick     = bus.left_btn  & ~r_prev_left;
    assign w_rclick     = bus.right_btn & ~r_prev_right;
    // Only states that react to clicks record them; everything else drops them.
    assign w_accept     = (r_state == S_IDLE) || (r_state == S_SRC_HELD);
    assign w_in_board   = (r_click_x >= c_X0) && (r_click_x <= c_X1) &&
                          (r_click_y >= c_Y0) && (r_click_y <= c_Y1);
    assign w_converting = (r_state == S_CONV_SRC) || (r_state == S_CONV_DST);

    assign w_rel_x  = r_click_x[8:0] - c_RX0;
    assign w_rel_y  = r_click_y[8:0] - c_RY0;
    assign w_ge_x   = (r_rel_x >= c_SQ);
    assign w_ge_y   = (r_rel_y >= c_SQ);
    assign w_nrel_x = w_ge_x ? (r_rel_x - c_SQ) : r_rel_x;
    assign w_nrel_y = w_ge_y ? (r_rel_y - c_SQ) : r_rel_y;
    assign w_ncnt_x = r_cnt_x + {2'b00, w_ge_x};
    assign w_ncnt_y = r_cnt_y + {2'b00, w_ge_y};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cursor_x <= 10'd320;
            r_cursor_y <= 10'd240;
        end else if (bus.frame_start) begin
            r_cursor_x <= (bus.mouse_x > c_MAX_X) ? c_MAX_X : bus.mouse_x;
            r_cursor_y <= (bus.mouse_y > c_MAX_Y) ? c_MAX_Y : bus.mouse_y;
        end
    end

    // Edge events are registered with their raw coordinates; the FSM acts one cycle later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev_left  <= 1'b0;
            r_prev_right <= 1'b0;
            r_lclick     <= 1'b0;
            r_rclick     <= 1'b0;
            r_click_x    <= 10'd0;
            r_click_y    <= 10'd0;
        end else begin
            r_prev_left  <= bus.left_btn;
            r_prev_right <= bus.right_btn;
            r_lclick     <= w_lclick & w_accept;
            r_rclick     <= w_rclick & w_accept;
            if (w_lclick && w_accept) begin
                r_click_x <= bus.mouse_x;
                r_click_y <= bus.mouse_y;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_rel_x      <= 9'd0;
            r_rel_y      <= 9'd0;
            r_cnt_x      <= 3'd0;
            r_cnt_y      <= 3'd0;
            r_step       <= 3'd0;
            r_sel_valid  <= 1'b0;
            r_sel_col    <= 3'd0;
            r_sel_row    <= 3'd0;
            r_move_valid <= 1'b0;
            r_src_col    <= 3'd0;
            r_src_row    <= 3'd0;
            r_dst_col    <= 3'd0;
            r_dst_row    <= 3'd0;
        end else begin
            if (w_converting) begin
                r_rel_x <= w_nrel_x;
                r_rel_y <= w_nrel_y;
                r_cnt_x <= w_ncnt_x;
                r_cnt_y <= w_ncnt_y;
                r_step  <= r_step + 3'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_lclick && w_in_board) begin
                        r_state <= S_CONV_SRC;
                        r_rel_x <= w_rel_x;
                        r_rel_y <= w_rel_y;
                        r_cnt_x <= 3'd0;
                        r_cnt_y <= 3'd0;
                        r_step  <= 3'd0;
                    end
                end
                S_CONV_SRC: begin
                    if (r_step == 3'd7) begin
                        r_state     <= S_SRC_HELD;
                        r_sel_valid <= 1'b1;
                        r_sel_col   <= w_ncnt_x;
                        r_sel_row   <= w_ncnt_y;
                    end
                end
                S_SRC_HELD: begin
                    if (r_rclick || (r_lclick && !w_in_board)) begin
                        r_state     <= S_IDLE;
                        r_sel_valid <= 1'b0;
                    end else if (r_lclick) begin
                        r_state <= S_CONV_DST;
                        r_rel_x <= w_rel_x;
                        r_rel_y <= w_rel_y;
                        r_cnt_x <= 3'd0;
                        r_cnt_y <= 3'd0;
                        r_step  <= 3'd0;
                    end
                end
                S_CONV_DST: begin
                    if (r_step == 3'd7) begin
                        if ((w_ncnt_x == r_sel_col) && (w_ncnt_y == r_sel_row)) begin
                            r_state     <= S_IDLE;
                            r_sel_valid <= 1'b0;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_move_valid <= 1'b1;
                            r_src_col    <= r_sel_col;
                            r_src_row    <= r_sel_row;
                            r_dst_col    <= w_ncnt_x;
                            r_dst_row    <= w_ncnt_y;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_move_valid && bus.move_ready) begin
                        r_state      <= S_IDLE;
                        r_move_valid <= 1'b0;
                        r_sel_valid  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cursor_x   = r_cursor_x;
    assign bus.cursor_y   = r_cursor_y;
    assign bus.sel_valid  = r_sel_valid;
    assign bus.sel_col    = r_sel_col;
    assign bus.sel_row    = r_sel_row;
    assign bus.move_valid = r_move_valid;
    assign bus.src_col    = r_src_col;
    assign bus.src_row    = r_src_row;
    assign bus.dst_col    = r_dst_col;
    assign bus.dst_row    = r_dst_row;
    assign bus.busy       = w_converting || (r_state == S_ISSUE);

endmodule
`default_nettype wire
